// File: rtl/mbe_pp_accumulator.sv
// mbe_pp_accumulator: sequentially sums the NPP weighted radix-4 Booth partial products into the NBIT x NBIT unsigned product.
module mbe_pp_accumulator #(
  parameter int NBIT = 11
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [((NBIT+2)/2)*(NBIT+1)-1:0] pp,
  input  logic [(NBIT+2)/2-1:0]           signs,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [2*NBIT-1:0]               product
);
  localparam int NPP = (NBIT + 2) / 2;
  localparam int PPW = NBIT + 1;
  localparam int PW = 2 * NBIT;
  localparam int CW = $clog2(NPP);
  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] acc_q, acc_d, prod_q, prod_d, term, sum;
  logic [NPP*PPW-1:0] pp_q, pp_d;
  logic [NPP-1:0] sg_q, sg_d;
  logic [PPW-1:0] pp_sel;
  logic sg_sel, take, last;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      acc_q <= '0;
      prod_q <= '0;
      pp_q <= '0;
      sg_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      prod_q <= prod_d;
      pp_q <= pp_d;
      sg_q <= sg_d;
    end
  end
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: state_d = in_valid ? ACC : IDLE;
      ACC: state_d = last ? DONE : ACC;
      DONE: state_d = out_ready ? (in_valid ? ACC : IDLE) : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    in_ready = (state_q == IDLE) || (state_q == DONE && out_ready);
    out_valid = state_q == DONE;
    product = prod_q;
  end
  // pp is an unsigned field; the sign enters only through +S and -(S<<PPW)
  always_comb begin
    take = in_valid && in_ready;
    last = (state_q == ACC) && (cnt_q == CW'(NPP - 1));
    pp_sel = pp_q[cnt_q*PPW +: PPW];
    sg_sel = sg_q[cnt_q];
    term = (PW'(pp_sel) + PW'(sg_sel) - (PW'(sg_sel) << PPW)) << {cnt_q, 1'b0};
    sum = acc_q + term;
    pp_d = take ? pp : pp_q;
    sg_d = take ? signs : sg_q;
    cnt_d = take ? '0 : (state_q == ACC ? cnt_q + CW'(1) : cnt_q);
    acc_d = take ? '0 : (state_q == ACC ? sum : acc_q);
    prod_d = last ? sum : prod_q;
  end
endmodule

// File: tb/tb_mbe_pp_accumulator.sv
// tb_mbe_pp_accumulator: directed and randomized checks of the Booth partial-product accumulator against A*B.
module tb_mbe_pp_accumulator;
  localparam int NBIT = 11;
  localparam int NPP = (NBIT + 2) / 2;
  localparam int PPW = NBIT + 1;
  localparam int PW = 2 * NBIT;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid;
  logic [NPP*PPW-1:0] pp = '0;
  logic [NPP-1:0] signs = '0;
  logic [PW-1:0] product, held;
  int checks = 0, errors = 0, lat;
  mbe_pp_accumulator #(.NBIT(NBIT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .pp(pp), .signs(signs), .out_valid(out_valid), .out_ready(out_ready), .product(product)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic encode(input logic [NBIT-1:0] a, input logic [NBIT-1:0] b,
                        output logic [NPP*PPW-1:0] p, output logic [NPP-1:0] s);
    logic [NBIT+1:0] bx;
    logic [2:0] g;
    logic [PPW-1:0] mag;
    logic neg;
    bx = {1'b0, b, 1'b0};
    for (int i = 0; i < NPP; i++) begin
      g = bx[2*i +: 3];
      neg = g[2] && (g != 3'b111);
      mag = (g == 3'b000 || g == 3'b111) ? '0 :
            (g == 3'b011 || g == 3'b100) ? {a, 1'b0} : {1'b0, a};
      p[i*PPW +: PPW] = neg ? ~mag : mag;
      s[i] = neg;
    end
  endtask
  task automatic load(input logic [NBIT-1:0] a, input logic [NBIT-1:0] b);
    logic [NPP*PPW-1:0] p;
    logic [NPP-1:0] s;
    encode(a, b, p, s);
    pp = p;
    signs = s;
    in_valid = 1;
  endtask
  task automatic wait_done();
    lat = 0;
    while (!out_valid && lat < 40) begin
      cyc();
      lat++;
    end
  endtask
  task automatic run(input logic [NBIT-1:0] a, input logic [NBIT-1:0] b);
    int n;
    load(a, b);
    n = 0;
    while (!in_ready && n < 40) begin
      cyc();
      n++;
    end
    cyc();
    in_valid = 0;
    pp = {$urandom, $urandom, $urandom};
    signs = NPP'($urandom);
    wait_done();
  endtask
  task automatic handoff();
    out_ready = 1;
    cyc();
    out_ready = 0;
  endtask
  initial begin
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_product", product, 0);
    chk("rst_in_ready", in_ready, 1);
    rst_n = 1;
    cyc();
    pp = '0;
    pp[0 +: PPW] = 12'hFFA;
    pp[PPW +: PPW] = 12'h005;
    signs = 6'b000001;
    in_valid = 1;
    cyc();
    in_valid = 0;
    for (int k = 1; k < NPP; k++) begin
      chk("lat_acc_in_ready", in_ready, 0);
      chk("lat_no_valid", out_valid, 0);
      cyc();
    end
    cyc();
    chk("5x3_valid", out_valid, 1);
    chk("5x3_product", product, 15);
    handoff();
    chk("handoff_valid", out_valid, 0);
    chk("handoff_in_ready", in_ready, 1);
    chk("product_retained", product, 15);
    run(2047, 2047);
    chk("max_latency", lat, NPP);
    chk("max_product", product, 4190209);
    handoff();
    run(0, 2047);
    chk("zero_product", product, 0);
    held = product;
    run(0, 0);
    handoff();
    run(1, 1);
    chk("1x1_product", product, 1);
    for (int k = 0; k < 10; k++) begin
      cyc();
      chk("hold_valid", out_valid, 1);
      chk("hold_product", product, 1);
      chk("hold_in_ready", in_ready, 0);
    end
    load(100, 200);
    out_ready = 1;
    #1;
    chk("b2b_in_ready", in_ready, 1);
    cyc();
    out_ready = 0;
    in_valid = 0;
    chk("b2b_valid_drop", out_valid, 0);
    wait_done();
    chk("b2b_latency", lat, NPP);
    chk("b2b_product", product, 20000);
    handoff();
    load(1234, 567);
    cyc();
    for (int k = 0; k < NPP - 1; k++) begin
      pp = {$urandom, $urandom, $urandom};
      signs = NPP'($urandom);
      in_valid = 1'($urandom);
      chk("acc_in_ready", in_ready, 0);
      cyc();
    end
    in_valid = 0;
    wait_done();
    chk("toggle_product", product, 699678);
    handoff();
    load(1500, 1500);
    cyc();
    in_valid = 0;
    cyc();
    cyc();
    cyc();
    rst_n = 0;
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_product", product, 0);
    chk("midrst_in_ready", in_ready, 1);
    for (int k = 0; k < 8; k++) begin
      cyc();
      chk("midrst_no_valid", out_valid, 0);
    end
    rst_n = 1;
    cyc();
    chk("post_rst_in_ready", in_ready, 1);
    run(77, 88);
    chk("post_rst_product", product, 6776);
    handoff();
    for (int v = 0; v < 2000; v++) begin
      logic [NBIT-1:0] a, b;
      int gap;
      a = NBIT'($urandom);
      b = NBIT'($urandom);
      gap = $urandom_range(0, 2);
      for (int k = 0; k < gap; k++) cyc();
      run(a, b);
      chk("rand_product", product, 64'(a) * 64'(b));
      gap = $urandom_range(0, 2);
      for (int k = 0; k < gap; k++) cyc();
      chk("rand_hold", out_valid, 1);
      handoff();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
